// File: rtl/axi_llc_data_way_ctrl_if.sv
// Way request/response and SRAM macro signals of one LLC data-way controller.
// The slave modport is the controller's view; master is the requesting units plus the macro.
interface axi_llc_data_way_ctrl_if #(
    parameter int IndexLength       = 7,
    parameter int BlockOffsetLength = 3,
    parameter int DataWidth         = 64
) ();
    logic                                       inp_valid;
    logic                                       inp_ready;
    logic [1:0]                                 inp_unit;
    logic                                       inp_we;
    logic [IndexLength-1:0]                     inp_line_addr;
    logic [BlockOffsetLength-1:0]               inp_blk_offset;
    logic [DataWidth-1:0]                       inp_data;
    logic [DataWidth/8-1:0]                     inp_strb;

    logic                                       out_valid;
    logic                                       out_ready;
    logic [1:0]                                 out_unit;
    logic [DataWidth-1:0]                       out_data;

    logic                                       sram_req;
    logic                                       sram_we;
    logic [IndexLength+BlockOffsetLength-1:0]   sram_addr;
    logic [DataWidth-1:0]                       sram_wdata;
    logic [DataWidth/8-1:0]                     sram_be;
    logic [DataWidth-1:0]                       sram_rdata;

    modport slave (
        input  inp_valid, inp_unit, inp_we, inp_line_addr, inp_blk_offset, inp_data, inp_strb,
        output inp_ready,
        output out_valid, out_unit, out_data,
        input  out_ready,
        output sram_req, sram_we, sram_addr, sram_wdata, sram_be,
        input  sram_rdata
    );

    modport master (
        output inp_valid, inp_unit, inp_we, inp_line_addr, inp_blk_offset, inp_data, inp_strb,
        input  inp_ready,
        input  out_valid, out_unit, out_data,
        output out_ready,
        input  sram_req, sram_we, sram_addr, sram_wdata, sram_be,
        output sram_rdata
    );
endinterface

// File: rtl/axi_llc_data_way_ctrl.sv
// Data-way controller: drives one SRAM macro, tracks reads over the macro latency and
// buffers read data in a credit-protected response FIFO so a stalled consumer loses nothing.
module axi_llc_data_way_ctrl #(
    parameter int IndexLength       = 7,
    parameter int BlockOffsetLength = 3,
    parameter int DataWidth         = 64,
    parameter int MacroLatency      = 1,
    parameter int OutDepth          = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    test_i,
    axi_llc_data_way_ctrl_if.slave  way
);
    localparam int CreditWidth = $clog2(OutDepth + 1);
    localparam int PtrWidth    = (OutDepth > 1) ? $clog2(OutDepth) : 1;
    localparam logic [CreditWidth-1:0] MaxCredit = CreditWidth'(OutDepth);
    localparam logic [PtrWidth-1:0]    LastSlot  = PtrWidth'(OutDepth - 1);

    typedef struct packed {
        logic [1:0]           unit;
        logic [DataWidth-1:0] data;
    } beat_t;

    logic [CreditWidth-1:0]  credit_q;
    logic [CreditWidth-1:0]  count_q;
    logic [MacroLatency-1:0] tag_valid_q;
    logic [1:0]              tag_unit_q [MacroLatency];
    beat_t                   fifo_q [OutDepth];
    logic [PtrWidth-1:0]     rd_ptr_q;
    logic [PtrWidth-1:0]     wr_ptr_q;

    logic ready;
    logic accept;
    logic read_accept;
    logic push;
    logic pop;
    logic out_valid;
    logic unused_test;

    // The FIFO is plain flops without a clock gate, so testmode has nothing to bypass here.
    assign unused_test = test_i;

    assign ready       = credit_q < MaxCredit;
    assign accept      = way.inp_valid & ready;
    assign read_accept = accept & ~way.inp_we;
    assign push        = tag_valid_q[MacroLatency-1];
    assign out_valid   = count_q != '0;
    assign pop         = out_valid & way.out_ready;

    assign way.inp_ready  = ready;
    assign way.sram_req   = accept;
    assign way.sram_we    = way.inp_we;
    assign way.sram_addr  = {way.inp_line_addr, way.inp_blk_offset};
    assign way.sram_wdata = way.inp_data;
    assign way.sram_be    = way.inp_we ? way.inp_strb : '0;

    assign way.out_valid = out_valid;
    assign way.out_unit  = out_valid ? fifo_q[rd_ptr_q].unit : '0;
    assign way.out_data  = out_valid ? fifo_q[rd_ptr_q].data : '0;

    // Tag pipeline mirrors the macro latency so the tail lines up with valid read data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tag_valid_q <= '0;
            for (int i = 0; i < MacroLatency; i++) begin
                tag_unit_q[i] <= '0;
            end
        end else begin
            tag_valid_q[0] <= read_accept;
            tag_unit_q[0]  <= way.inp_unit;
            for (int i = 1; i < MacroLatency; i++) begin
                tag_valid_q[i] <= tag_valid_q[i-1];
                tag_unit_q[i]  <= tag_unit_q[i-1];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            credit_q <= '0;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            if (read_accept && !pop) begin
                credit_q <= credit_q + CreditWidth'(1);
            end else if (!read_accept && pop) begin
                credit_q <= credit_q - CreditWidth'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CreditWidth'(1);
            end else if (!push && pop) begin
                count_q <= count_q - CreditWidth'(1);
            end
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == LastSlot) ? '0 : wr_ptr_q + PtrWidth'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == LastSlot) ? '0 : rd_ptr_q + PtrWidth'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= {tag_unit_q[MacroLatency-1], way.sram_rdata};
        end
    end

    no_push_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push && count_q == MaxCredit));
    credit_in_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        credit_q <= MaxCredit);
endmodule

// File: tb/tb_axi_llc_data_way_ctrl.sv
// Bench for axi_llc_data_way_ctrl: two instances (latency 1 and 3) against a macro model
// and a queue-of-responses reference model with per-response availability cycles.
module tb_axi_llc_data_way_ctrl;
    typedef struct {
        logic [1:0]  unit;
        logic [63:0] data;
        int          readyAt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic test;
    logic cur;
    logic fillMem;

    logic        inpValid;
    logic        inpWe;
    logic [1:0]  inpUnit;
    logic [6:0]  inpLine;
    logic [2:0]  inpBlk;
    logic [63:0] inpData;
    logic [7:0]  inpStrb;
    logic        outReady;

    logic [63:0] mem [1024];
    logic [63:0] pipeA;
    logic [63:0] pipeB [3];

    exp_t expQ[$];
    int   curML;
    int   curOD;
    int   cycle;
    int   nChecks;
    int   nFail;

    always #5 clk = ~clk;

    axi_llc_data_way_ctrl_if ifA ();
    axi_llc_data_way_ctrl_if ifB ();

    axi_llc_data_way_ctrl #(.MacroLatency(1), .OutDepth(4)) dutA (
        .clk_i(clk), .rst_ni(rst_n), .test_i(test), .way(ifA));
    axi_llc_data_way_ctrl #(.MacroLatency(3), .OutDepth(4)) dutB (
        .clk_i(clk), .rst_ni(rst_n), .test_i(test), .way(ifB));

    assign ifA.inp_valid      = inpValid & ~cur;
    assign ifB.inp_valid      = inpValid & cur;
    assign ifA.inp_unit       = inpUnit;
    assign ifB.inp_unit       = inpUnit;
    assign ifA.inp_we         = inpWe;
    assign ifB.inp_we         = inpWe;
    assign ifA.inp_line_addr  = inpLine;
    assign ifB.inp_line_addr  = inpLine;
    assign ifA.inp_blk_offset = inpBlk;
    assign ifB.inp_blk_offset = inpBlk;
    assign ifA.inp_data       = inpData;
    assign ifB.inp_data       = inpData;
    assign ifA.inp_strb       = inpStrb;
    assign ifB.inp_strb       = inpStrb;
    assign ifA.out_ready      = outReady & ~cur;
    assign ifB.out_ready      = outReady & cur;
    assign ifA.sram_rdata     = pipeA;
    assign ifB.sram_rdata     = pipeB[2];

    logic        obsReady, obsValid, obsReq, obsWe;
    logic [1:0]  obsUnit;
    logic [63:0] obsData, obsWdata;
    logic [9:0]  obsAddr;
    logic [7:0]  obsBe;

    assign obsReady = cur ? ifB.inp_ready  : ifA.inp_ready;
    assign obsValid = cur ? ifB.out_valid  : ifA.out_valid;
    assign obsUnit  = cur ? ifB.out_unit   : ifA.out_unit;
    assign obsData  = cur ? ifB.out_data   : ifA.out_data;
    assign obsReq   = cur ? ifB.sram_req   : ifA.sram_req;
    assign obsWe    = cur ? ifB.sram_we    : ifA.sram_we;
    assign obsAddr  = cur ? ifB.sram_addr  : ifA.sram_addr;
    assign obsWdata = cur ? ifB.sram_wdata : ifA.sram_wdata;
    assign obsBe    = cur ? ifB.sram_be    : ifA.sram_be;

    // Macro model: byte-masked writes, read data valid exactly MacroLatency cycles after the
    // request, random garbage on the read bus otherwise.
    always @(posedge clk) begin : macro
        logic [63:0] merged;
        if (fillMem) begin
            for (int i = 0; i < 1024; i++) begin
                mem[i] <= {$urandom, $urandom};
            end
        end else begin
            if (ifA.sram_req && ifA.sram_we) begin
                merged = mem[ifA.sram_addr];
                for (int b = 0; b < 8; b++) begin
                    if (ifA.sram_be[b]) merged[8*b +: 8] = ifA.sram_wdata[8*b +: 8];
                end
                mem[ifA.sram_addr] <= merged;
            end
            if (ifB.sram_req && ifB.sram_we) begin
                merged = mem[ifB.sram_addr];
                for (int b = 0; b < 8; b++) begin
                    if (ifB.sram_be[b]) merged[8*b +: 8] = ifB.sram_wdata[8*b +: 8];
                end
                mem[ifB.sram_addr] <= merged;
            end
        end
        pipeA    <= (ifA.sram_req && !ifA.sram_we) ? mem[ifA.sram_addr] : {$urandom, $urandom};
        pipeB[0] <= (ifB.sram_req && !ifB.sram_we) ? mem[ifB.sram_addr] : {$urandom, $urandom};
        pipeB[1] <= pipeB[0];
        pipeB[2] <= pipeB[1];
    end

    task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input logic expReady, input logic expValid);
        checkValue("inp_ready", obsReady, expReady);
        checkValue("out_valid", obsValid, expValid);
        if (expValid) begin
            checkValue("out_unit", obsUnit, expQ[0].unit);
            checkValue("out_data", obsData, expQ[0].data);
        end
        checkValue("sram_req", obsReq, inpValid && expReady);
        if (inpValid && expReady) begin
            checkValue("sram_addr", obsAddr, {inpLine, inpBlk});
            checkValue("sram_we", obsWe, inpWe);
            checkValue("sram_be", obsBe, inpWe ? inpStrb : 8'h00);
            if (inpWe) checkValue("sram_wdata", obsWdata, inpData);
        end
    endtask

    // One clock cycle: drive after the edge, check at the falling edge, advance the model.
    task automatic applyStimulus(input logic v, input logic we, input logic [1:0] unit,
                                 input logic [6:0] line, input logic [2:0] blk,
                                 input logic [63:0] data, input logic [7:0] strb,
                                 input logic oRdy);
        logic        expReady, expValid, doRead, doPop;
        logic [63:0] rdData;
        inpValid = v;
        inpWe    = we;
        inpUnit  = unit;
        inpLine  = line;
        inpBlk   = blk;
        inpData  = data;
        inpStrb  = strb;
        outReady = oRdy;
        @(negedge clk);
        expReady = expQ.size() < curOD;
        expValid = (expQ.size() > 0) && (expQ[0].readyAt <= cycle);
        checkOutput(expReady, expValid);
        doRead = v && expReady && !we;
        doPop  = expValid && oRdy;
        rdData = mem[{line, blk}];
        @(posedge clk);
        if (doPop) void'(expQ.pop_front());
        if (doRead) expQ.push_back('{unit: unit, data: rdData, readyAt: cycle + curML + 1});
        cycle++;
        #1;
    endtask

    task automatic idle(input int n, input logic oRdy);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 2'd0, 7'd0, 3'd0, '0, '0, oRdy);
    endtask

    task automatic readReq(input logic [1:0] unit, input logic oRdy);
        applyStimulus(1'b1, 1'b0, unit, 7'($urandom_range(0, 127)), 3'($urandom_range(0, 7)),
                      '0, '0, oRdy);
    endtask

    task automatic randomTraffic(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                          2'($urandom_range(0, 3)), 7'($urandom_range(0, 127)),
                          3'($urandom_range(0, 7)), {$urandom, $urandom},
                          8'($urandom_range(0, 255)), $urandom_range(0, 3) != 0);
        end
    endtask

    // Asynchronous reset: outputs must clear before any clock edge arrives.
    task automatic applyReset();
        rst_n    = 1'b0;
        inpValid = 1'b0;
        #1;
        checkValue("rst_out_valid", obsValid, 1'b0);
        checkValue("rst_inp_ready", obsReady, 1'b1);
        checkValue("rst_sram_req", obsReq, 1'b0);
        checkValue("rst_out_unit", obsUnit, 2'd0);
        checkValue("rst_out_data", obsData, 64'd0);
        expQ.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle++;
    endtask

    initial begin
        cur = 1'b0; curML = 1; curOD = 4; cycle = 0; nChecks = 0; nFail = 0;
        test = 1'b0; fillMem = 1'b1; rst_n = 1'b1;
        inpValid = 1'b0; inpWe = 1'b0; inpUnit = '0; inpLine = '0; inpBlk = '0;
        inpData = '0; inpStrb = '0; outReady = 1'b0;
        #1;
        $display("[TB] latency 1: reset, single read, write then read back");
        applyReset();
        fillMem = 1'b0;
        applyStimulus(1'b1, 1'b0, 2'd1, 7'd5, 3'd2, '0, '0, 1'b1);
        idle(3, 1'b1);
        applyStimulus(1'b1, 1'b1, 2'd0, 7'd1, 3'd0, 64'hA5A5_A5A5_A5A5_A5A5, 8'h0F, 1'b1);
        applyStimulus(1'b1, 1'b0, 2'd2, 7'd1, 3'd0, '0, '0, 1'b1);
        idle(3, 1'b1);

        $display("[TB] latency 1: credit exhaustion under backpressure");
        for (int i = 0; i < 6; i++) readReq(2'(i), 1'b0);
        idle(2, 1'b0);
        idle(8, 1'b1);

        $display("[TB] latency 1: streaming reads and random traffic");
        for (int i = 0; i < 8; i++) readReq(2'(i), 1'b1);
        idle(4, 1'b1);
        randomTraffic(80);
        idle(10, 1'b1);

        $display("[TB] latency 3: single read, random traffic, reset with reads pending");
        cur = 1'b1; curML = 3;
        applyStimulus(1'b1, 1'b0, 2'd3, 7'd9, 3'd7, '0, '0, 1'b1);
        idle(6, 1'b1);
        randomTraffic(60);
        idle(12, 1'b1);
        readReq(2'd1, 1'b0);
        idle(1, 1'b0);
        readReq(2'd2, 1'b0);
        readReq(2'd3, 1'b0);
        applyReset();
        readReq(2'd0, 1'b1);
        idle(6, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
